// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: UART receive front-end.
// 2-flop input synchroniser, 8N1 deserialiser at a fixed CLKS_PER_BIT ratio,
// and a small first-word-fall-through FIFO popped by the register interface.
// Optional build macro UART_RX_PARITY_EN switches the frame to 8E1 and adds
// a sticky parity_err output.
module uart_rx_fifo #(
    parameter int CLKS_PER_BIT = 434,
    parameter int FIFO_AW      = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               uart_rx,
    input  logic               rd_en,
    input  logic               err_clr,
    output logic [7:0]         rx_data,
    output logic               rx_valid,
    output logic [FIFO_AW:0]   count,
    output logic               done,
    output logic               frame_err,
`ifdef UART_RX_PARITY_EN
    output logic               parity_err,
`endif
    output logic               overrun
);

    localparam int DEPTH = 1 << FIFO_AW;
    localparam int CW    = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [FIFO_AW:0] FULL_CNT = (FIFO_AW+1)'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_RX_PARITY_EN
        S_PARITY,
`endif
        S_STOP,
        S_WAIT_HIGH
    } state_t;

    // ------------------------------------------------------------------
    // Input synchroniser
    // ------------------------------------------------------------------
    logic meta_q, rxs_q;

    // Two flops; reset to the idle-high line level so no false start bit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta_q <= 1'b1;
            rxs_q  <= 1'b1;
        end else begin
            meta_q <= uart_rx;
            rxs_q  <= meta_q;
        end
    end

    // ------------------------------------------------------------------
    // Deserialiser FSM
    // ------------------------------------------------------------------
    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          done_q, done_d;
    logic          push;
    logic          ferr_set;
    logic          byte_ok;
`ifdef UART_RX_PARITY_EN
    logic          par_bad_q, par_bad_d;
    logic          perr_set;
    logic          perr_q;
    assign byte_ok = !par_bad_q;
`else
    assign byte_ok = 1'b1;
`endif

    // State, bit/clock counters, shift register and done pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            done_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            done_q  <= done_d;
`ifdef UART_RX_PARITY_EN
            par_bad_q <= par_bad_d;
`endif
        end
    end

    // Next-state: the clock counter free-runs inside a bit and is cleared
    // on every sample so the next sample lands one bit time later.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q + CW'(1);
        bit_d    = bit_q;
        shift_d  = shift_q;
        done_d   = 1'b0;
        push     = 1'b0;
        ferr_set = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bad_d = par_bad_q;
        perr_set  = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (!rxs_q) state_d = S_START;
            end
            S_START: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d = '0;
                    bit_d = '0;
                    // A line back high at mid start bit was only a glitch.
                    state_d = rxs_q ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = '0;
                    shift_d = {rxs_q, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
`ifdef UART_RX_PARITY_EN
                    if (bit_q == 3'd7) state_d = S_PARITY;
`else
                    if (bit_q == 3'd7) state_d = S_STOP;
`endif
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d     = '0;
                    par_bad_d = rxs_q ^ (^shift_q);
                    perr_set  = rxs_q ^ (^shift_q);
                    state_d   = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d = '0;
                    if (rxs_q) begin
                        push    = byte_ok;
                        done_d  = byte_ok;
                        state_d = S_IDLE;
                    end else begin
                        ferr_set = 1'b1;
                        state_d  = S_WAIT_HIGH;
                    end
                end
            end
            S_WAIT_HIGH: begin
                // Absorb a held-low line so a break reports one error only.
                cnt_d = '0;
                if (rxs_q) state_d = S_IDLE;
            end
            default: begin
                cnt_d   = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FIFO
    // ------------------------------------------------------------------
    logic [7:0]         mem_q [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [FIFO_AW:0]   cnt_fifo_q, cnt_fifo_d;
    logic               full, do_pop, do_push, ovf_set;
    logic               ferr_q, ovr_q;

    assign full    = (cnt_fifo_q == FULL_CNT);
    assign do_pop  = rd_en && (cnt_fifo_q != '0);
    // When full, a same-cycle pop frees the slot the push lands in.
    assign do_push = push && (!full || do_pop);
    assign ovf_set = push && full && !do_pop;

    // Occupancy update from the push/pop pair.
    always_comb begin
        cnt_fifo_d = cnt_fifo_q;
        case ({do_push, do_pop})
            2'b10:   cnt_fifo_d = cnt_fifo_q + (FIFO_AW+1)'(1);
            2'b01:   cnt_fifo_d = cnt_fifo_q - (FIFO_AW+1)'(1);
            default: cnt_fifo_d = cnt_fifo_q;
        endcase
    end

    // Storage and pointers; storage is cleared so rx_data reads 0 in reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_fifo_q <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= shift_q;
                wr_ptr_q        <= wr_ptr_q + FIFO_AW'(1);
            end
            if (do_pop) rd_ptr_q <= rd_ptr_q + FIFO_AW'(1);
            cnt_fifo_q <= cnt_fifo_d;
        end
    end

    // Sticky error flags; a new error outranks a same-cycle clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ferr_q <= 1'b0;
            ovr_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            perr_q <= 1'b0;
`endif
        end else begin
            ferr_q <= (ferr_q && !err_clr) || ferr_set;
            ovr_q  <= (ovr_q  && !err_clr) || ovf_set;
`ifdef UART_RX_PARITY_EN
            perr_q <= (perr_q && !err_clr) || perr_set;
`endif
        end
    end

    assign rx_data   = mem_q[rd_ptr_q];
    assign rx_valid  = (cnt_fifo_q != '0);
    assign count     = cnt_fifo_q;
    assign done      = done_q;
    assign frame_err = ferr_q;
    assign overrun   = ovr_q;
`ifdef UART_RX_PARITY_EN
    assign parity_err = perr_q;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo. Bit time is scaled down (CPB clocks per bit) to
// keep run time short; glitch length is scaled in proportion.
module tb_uart_rx_fifo;

    localparam int CPB = 64;
    localparam int AW  = 2;
    localparam int DEP = 1 << AW;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          uart_rx = 1'b1;
    logic          rd_en = 1'b0;
    logic          err_clr = 1'b0;
    logic [7:0]    rx_data;
    logic          rx_valid;
    logic [AW:0]   count;
    logic          done;
    logic          frame_err;
    logic          overrun;
`ifdef UART_RX_PARITY_EN
    logic          parity_err;
`endif

    int n_chk  = 0;
    int n_pass = 0;

    // done monitor: counts high cycles and snapshots the FIFO head there
    int         done_cnt = 0;
    logic       done_valid = 1'b0;
    logic [7:0] done_data = 8'h00;

    // reference model
    logic [7:0] m_q[$];
    logic       m_ferr = 1'b0;
    logic       m_ovr  = 1'b0;

    uart_rx_fifo #(.CLKS_PER_BIT(CPB), .FIFO_AW(AW)) dut (
        .clk(clk), .rst(rst), .uart_rx(uart_rx), .rd_en(rd_en),
        .err_clr(err_clr), .rx_data(rx_data), .rx_valid(rx_valid),
        .count(count), .done(done), .frame_err(frame_err),
`ifdef UART_RX_PARITY_EN
        .parity_err(parity_err),
`endif
        .overrun(overrun)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst && done === 1'b1) begin
            done_cnt   = done_cnt + 1;
            done_valid = rx_valid;
            done_data  = rx_data;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: run did not finish (got timeout, need completion)");
        $fatal(1);
    end

    // ---------------- stimulus helpers ----------------
    task automatic bit_time(input logic v);
        uart_rx = v;
        repeat (CPB) @(negedge clk);
    endtask

    // Line is left at the stop-bit level afterwards.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        bit_time(1'b0);
        for (int i = 0; i < 8; i++) bit_time(b[i]);
`ifdef UART_RX_PARITY_EN
        bit_time(^b);
`endif
        bit_time(stop_bit);
    endtask

    task automatic idle(input int n);
        uart_rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic pop();
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
    endtask

    task automatic clr();
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
    endtask

    function automatic void model_frame(input logic [7:0] b, input logic ok);
        if (!ok) m_ferr = 1'b1;
        else if (m_q.size() == DEP) m_ovr = 1'b1;
        else m_q.push_back(b);
    endfunction

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        n_chk++; if ({rx_valid, done, frame_err, overrun} !== 4'b0) $display("FAIL reset_flags: got %b need 0000", {rx_valid, done, frame_err, overrun}); else n_pass++;
        n_chk++; if (count !== 3'd0) $display("FAIL reset_count: got %0d need 0", count); else n_pass++;
        n_chk++; if (rx_data !== 8'h00) $display("FAIL reset_data: got %h need 00", rx_data); else n_pass++;
        rst = 1'b1;
        idle(CPB);
    endtask

    task automatic test_single();
        int d0 = done_cnt;
        send_frame(8'h75, 1'b1);
        idle(4);
        n_chk++; if (done_cnt - d0 !== 1) $display("FAIL single_done: got %0d pulse cycles need 1", done_cnt - d0); else n_pass++;
        n_chk++; if (done_valid !== 1'b1 || done_data !== 8'h75) $display("FAIL single_latency: at done valid=%b data=%h need 1/75", done_valid, done_data); else n_pass++;
        n_chk++; if (rx_valid !== 1'b1 || rx_data !== 8'h75) $display("FAIL single_head: valid=%b data=%h need 1/75", rx_valid, rx_data); else n_pass++;
        n_chk++; if (count !== 3'd1) $display("FAIL single_count: got %0d need 1", count); else n_pass++;
        pop();
        n_chk++; if (rx_valid !== 1'b0 || count !== 3'd0) $display("FAIL single_pop: valid=%b count=%0d need 0/0", rx_valid, count); else n_pass++;
    endtask

    task automatic test_back_to_back();
        send_frame(8'h75, 1'b1);
        send_frame(8'hC0, 1'b1);
        idle(4);
        n_chk++; if (count !== 3'd2 || rx_data !== 8'h75) $display("FAIL b2b_fill: count=%0d data=%h need 2/75", count, rx_data); else n_pass++;
        pop();
        n_chk++; if (count !== 3'd1 || rx_data !== 8'hC0) $display("FAIL b2b_pop1: count=%0d data=%h need 1/c0", count, rx_data); else n_pass++;
        pop();
        n_chk++; if (count !== 3'd0 || rx_valid !== 1'b0) $display("FAIL b2b_pop2: count=%0d valid=%b need 0/0", count, rx_valid); else n_pass++;
        pop();
        n_chk++; if (count !== 3'd0 || rx_valid !== 1'b0) $display("FAIL b2b_empty_pop: count=%0d valid=%b need 0/0", count, rx_valid); else n_pass++;
    endtask

    task automatic test_overrun();
        int d0 = done_cnt;
        for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1);
        idle(4);
        n_chk++; if (count !== 3'd4 || overrun !== 1'b1) $display("FAIL ovr_full: count=%0d overrun=%b need 4/1", count, overrun); else n_pass++;
        n_chk++; if (done_cnt - d0 !== 5) $display("FAIL ovr_done: got %0d need 5", done_cnt - d0); else n_pass++;
        for (int i = 1; i <= 4; i++) begin
            n_chk++; if (rx_data !== 8'(i)) $display("FAIL ovr_pop%0d: got %h need %h", i, rx_data, 8'(i)); else n_pass++;
            pop();
        end
        n_chk++; if (count !== 3'd0) $display("FAIL ovr_drain: got %0d need 0", count); else n_pass++;
        clr();
        n_chk++; if (overrun !== 1'b0) $display("FAIL ovr_clr: got %b need 0", overrun); else n_pass++;
    endtask

    task automatic test_glitch();
        int d0 = done_cnt;
        uart_rx = 1'b0;
        repeat (CPB / 4) @(negedge clk);
        idle(2 * CPB);
        n_chk++; if (done_cnt - d0 !== 0 || frame_err !== 1'b0 || overrun !== 1'b0 || count !== 3'd0)
            $display("FAIL glitch_quiet: done=%0d ferr=%b ovr=%b count=%0d need 0/0/0/0", done_cnt - d0, frame_err, overrun, count); else n_pass++;
        send_frame(8'h5A, 1'b1);
        idle(4);
        n_chk++; if (count !== 3'd1 || rx_data !== 8'h5A) $display("FAIL glitch_next: count=%0d data=%h need 1/5a", count, rx_data); else n_pass++;
        pop();
    endtask

    task automatic test_break();
        int d0 = done_cnt;
        send_frame(8'h00, 1'b0);
        repeat (5000) @(negedge clk);
        idle(8);
        n_chk++; if (frame_err !== 1'b1 || count !== 3'd0 || done_cnt - d0 !== 0)
            $display("FAIL break_err: ferr=%b count=%0d done=%0d need 1/0/0", frame_err, count, done_cnt - d0); else n_pass++;
        send_frame(8'h33, 1'b1);
        idle(4);
        n_chk++; if (count !== 3'd1 || rx_data !== 8'h33 || frame_err !== 1'b1)
            $display("FAIL break_next: count=%0d data=%h ferr=%b need 1/33/1", count, rx_data, frame_err); else n_pass++;
        clr();
        n_chk++; if (frame_err !== 1'b0) $display("FAIL break_clr: got %b need 0", frame_err); else n_pass++;
        pop();
    endtask

    task automatic test_reset_mid();
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        idle(4);
        n_chk++; if (count !== 3'd2) $display("FAIL rstmid_pre: count=%0d need 2", count); else n_pass++;
        bit_time(1'b0);
        bit_time(1'b1);
        uart_rx = 1'b0;
        repeat (CPB / 2) @(negedge clk);
        rst = 1'b0;
        #1;
        n_chk++; if ({rx_valid, done, frame_err, overrun} !== 4'b0 || count !== 3'd0 || rx_data !== 8'h00)
            $display("FAIL rstmid_out: flags=%b count=%0d data=%h need 0000/0/00", {rx_valid, done, frame_err, overrun}, count, rx_data); else n_pass++;
        uart_rx = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        idle(CPB);
        send_frame(8'hA5, 1'b1);
        idle(4);
        n_chk++; if (count !== 3'd1 || rx_data !== 8'hA5) $display("FAIL rstmid_fresh: count=%0d data=%h need 1/a5", count, rx_data); else n_pass++;
        pop();
    endtask

    task automatic test_random();
        clr();
        m_q.delete();
        m_ferr = 1'b0;
        m_ovr  = 1'b0;
        for (int k = 0; k < 16; k++) begin
            logic [7:0] b;
            logic       ok;
            int         d0;
            int         np;
            b  = 8'($urandom);
            ok = ($urandom_range(5) != 0);
            d0 = done_cnt;
            send_frame(b, ok);
            idle(6);
            model_frame(b, ok);
            n_chk++; if (done_cnt - d0 !== (ok ? 1 : 0)) $display("FAIL rnd%0d_done: got %0d need %0d", k, done_cnt - d0, ok ? 1 : 0); else n_pass++;
            n_chk++; if (count !== (AW+1)'(m_q.size())) $display("FAIL rnd%0d_count: got %0d need %0d", k, count, m_q.size()); else n_pass++;
            n_chk++; if (frame_err !== m_ferr || overrun !== m_ovr) $display("FAIL rnd%0d_flags: ferr=%b ovr=%b need %b/%b", k, frame_err, overrun, m_ferr, m_ovr); else n_pass++;
            if (m_q.size() > 0) begin
                n_chk++; if (rx_data !== m_q[0]) $display("FAIL rnd%0d_head: got %h need %h", k, rx_data, m_q[0]); else n_pass++;
            end
            np = $urandom_range(1);
            for (int p = 0; p < np; p++) begin
                pop();
                if (m_q.size() > 0) void'(m_q.pop_front());
            end
            if ($urandom_range(3) == 0) begin
                clr();
                m_ferr = 1'b0;
                m_ovr  = 1'b0;
            end
            n_chk++; if (count !== (AW+1)'(m_q.size()) || rx_valid !== (m_q.size() > 0) || frame_err !== m_ferr || overrun !== m_ovr)
                $display("FAIL rnd%0d_after: count=%0d valid=%b ferr=%b ovr=%b need %0d/%b/%b/%b",
                         k, count, rx_valid, frame_err, overrun, m_q.size(), m_q.size() > 0, m_ferr, m_ovr); else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_overrun();
        test_glitch();
        test_break();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
